// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared state encodings and widths for the pipeline sequencer
package pipe_ctrl_pkg;

  localparam int PC_DATA_HIGH_GPR = 32;
  localparam int PC_GPR_AW        = $clog2(PC_DATA_HIGH_GPR);

  localparam logic [1:0] PC_RUN      = 2'd0;
  localparam logic [1:0] PC_MEM_WAIT = 2'd1;
  localparam logic [1:0] PC_FLUSH    = 2'd2;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// rtl/pipe_ctrl_hazard_detect.sv - load-use hazard compare between EX destination and ID sources
module pipe_ctrl_hazard_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int GPR_AW = PC_GPR_AW
) (
  input  logic              id_en,
  input  logic [GPR_AW-1:0] id_rs1_addr,
  input  logic [GPR_AW-1:0] id_rs2_addr,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic              ex_en,
  input  logic              ex_is_load,
  input  logic              ex_gpr_we_,
  input  logic [GPR_AW-1:0] ex_dst_addr,
  output logic              lu
);

  logic load_writes;
  logic src_match;

  // x0 is hardwired zero, so a load targeting it never creates a dependency
  assign load_writes = ex_en & ex_is_load & ~ex_gpr_we_ & (ex_dst_addr != '0);
  assign src_match   = (id_rs1_used & (id_rs1_addr == ex_dst_addr)) |
                       (id_rs2_used & (id_rs2_addr == ex_dst_addr));
  assign lu          = load_writes & id_en & src_match;

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - stall/flush sequencer for IF/ID, ID/EX and EX/MEM stage registers
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int GPR_AW       = PC_GPR_AW,
  parameter int MEM_TIMEOUT  = 256,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_en,
  input  logic [GPR_AW-1:0] id_rs1_addr,
  input  logic [GPR_AW-1:0] id_rs2_addr,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic              ex_en,
  input  logic              ex_is_load,
  input  logic              ex_gpr_we_,
  input  logic [GPR_AW-1:0] ex_dst_addr,
  input  logic              ex_branch_taken,
  input  logic              trap_req,
  input  logic              mem_req,
  input  logic              mem_ack,
  output logic              if_stall,
  output logic              id_stall,
  output logic              ex_stall,
  output logic              id_flush,
  output logic              ex_flush,
  output logic              trap_ack,
  output logic              mem_timeout
);

  localparam int TW = $clog2(MEM_TIMEOUT);
  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [TW-1:0] TCNT_LAST  = TW'(MEM_TIMEOUT - 1);
  localparam logic [FW-1:0] FCNT_START = FW'(FLUSH_CYCLES - 1);
  localparam bit            FLUSH_EXT  = (FLUSH_CYCLES > 1);

  logic [1:0]    state_q, state_d;
  logic [TW-1:0] tcnt_q,  tcnt_d;
  logic [FW-1:0] fcnt_q,  fcnt_d;

  logic lu;
  logic if_stall_c, id_stall_c, ex_stall_c;
  logic id_flush_c, ex_flush_c, trap_ack_c, mem_timeout_c;

  pipe_ctrl_hazard_detect #(
    .GPR_AW (GPR_AW)
  ) u_hazard_detect (
    .id_en       (id_en),
    .id_rs1_addr (id_rs1_addr),
    .id_rs2_addr (id_rs2_addr),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .ex_en       (ex_en),
    .ex_is_load  (ex_is_load),
    .ex_gpr_we_  (ex_gpr_we_),
    .ex_dst_addr (ex_dst_addr),
    .lu          (lu)
  );

  always_comb begin
    state_d       = state_q;
    tcnt_d        = tcnt_q;
    fcnt_d        = fcnt_q;
    if_stall_c    = 1'b0;
    id_stall_c    = 1'b0;
    ex_stall_c    = 1'b0;
    id_flush_c    = 1'b0;
    ex_flush_c    = 1'b0;
    trap_ack_c    = 1'b0;
    mem_timeout_c = 1'b0;

    case (state_q)
      PC_RUN: begin
        if (trap_req || ex_branch_taken) begin
          id_flush_c = 1'b1;
          ex_flush_c = 1'b1;
          trap_ack_c = trap_req;
          if (FLUSH_EXT) begin
            state_d = PC_FLUSH;
            fcnt_d  = FCNT_START;
          end
        end else if (mem_req && !mem_ack) begin
          if_stall_c = 1'b1;
          id_stall_c = 1'b1;
          ex_stall_c = 1'b1;
          state_d    = PC_MEM_WAIT;
          tcnt_d     = '0;
        end else if (lu) begin
          // one bubble into EX while the load drains; it leaves EX on the next edge
          if_stall_c = 1'b1;
          id_stall_c = 1'b1;
          ex_flush_c = 1'b1;
        end
      end

      PC_MEM_WAIT: begin
        if (!mem_ack && (tcnt_q == TCNT_LAST)) begin
          mem_timeout_c = 1'b1;
          id_flush_c    = 1'b1;
          ex_flush_c    = 1'b1;
          state_d       = PC_RUN;
          if (FLUSH_EXT) begin
            state_d = PC_FLUSH;
            fcnt_d  = FCNT_START;
          end
        end else begin
          if_stall_c = 1'b1;
          id_stall_c = 1'b1;
          ex_stall_c = 1'b1;
          if (mem_ack) begin
            state_d = PC_RUN;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
      end

      PC_FLUSH: begin
        id_flush_c = 1'b1;
        ex_flush_c = 1'b1;
        fcnt_d     = fcnt_q - FW'(1);
        if (fcnt_q == FW'(1)) begin
          state_d = PC_RUN;
        end
      end

      default: begin
        state_d = PC_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= PC_RUN;
      tcnt_q  <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // outputs are forced low for as long as reset is held, not just after the edge
  assign if_stall    = reset & if_stall_c;
  assign id_stall    = reset & id_stall_c;
  assign ex_stall    = reset & ex_stall_c;
  assign id_flush    = reset & id_flush_c;
  assign ex_flush    = reset & ex_flush_c;
  assign trap_ack    = reset & trap_ack_c;
  assign mem_timeout = reset & mem_timeout_c;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed and randomized self-checking bench for pipe_ctrl
module tb_pipe_ctrl;

  localparam int AW = 5;
  localparam int MT = 4;
  localparam int FC = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          id_en, id_rs1_used, id_rs2_used;
  logic [AW-1:0] id_rs1_addr, id_rs2_addr, ex_dst_addr;
  logic          ex_en, ex_is_load, ex_gpr_we_, ex_branch_taken;
  logic          trap_req, mem_req, mem_ack;
  logic          if_stall, id_stall, ex_stall, id_flush, ex_flush, trap_ack, mem_timeout;
  logic [6:0]    obs;

  int errs = 0;
  int checks = 0;

  // model state: remaining forced-flush cycles, memory wait tracking
  int  m_flush_left;
  bit  m_waiting;
  int  m_waited;

  always #5 clk = ~clk;

  pipe_ctrl #(
    .GPR_AW       (AW),
    .MEM_TIMEOUT  (MT),
    .FLUSH_CYCLES (FC)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .id_en           (id_en),
    .id_rs1_addr     (id_rs1_addr),
    .id_rs2_addr     (id_rs2_addr),
    .id_rs1_used     (id_rs1_used),
    .id_rs2_used     (id_rs2_used),
    .ex_en           (ex_en),
    .ex_is_load      (ex_is_load),
    .ex_gpr_we_      (ex_gpr_we_),
    .ex_dst_addr     (ex_dst_addr),
    .ex_branch_taken (ex_branch_taken),
    .trap_req        (trap_req),
    .mem_req         (mem_req),
    .mem_ack         (mem_ack),
    .if_stall        (if_stall),
    .id_stall        (id_stall),
    .ex_stall        (ex_stall),
    .id_flush        (id_flush),
    .ex_flush        (ex_flush),
    .trap_ack        (trap_ack),
    .mem_timeout     (mem_timeout)
  );

  // {if_stall, id_stall, ex_stall, id_flush, ex_flush, trap_ack, mem_timeout}
  assign obs = {if_stall, id_stall, ex_stall, id_flush, ex_flush, trap_ack, mem_timeout};

  task automatic check_out(input string tag, input logic [6:0] got, input logic [6:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic clear_in();
    id_en = 0; id_rs1_addr = 0; id_rs2_addr = 0; id_rs1_used = 0; id_rs2_used = 0;
    ex_en = 0; ex_is_load = 0; ex_gpr_we_ = 1; ex_dst_addr = 0;
    ex_branch_taken = 0; trap_req = 0; mem_req = 0; mem_ack = 0;
  endtask

  task automatic set_load(input int dst, input int rs1, input int rs2, input bit u1, input bit u2);
    ex_en = 1; ex_is_load = 1; ex_gpr_we_ = 0; ex_dst_addr = AW'(dst);
    id_en = 1; id_rs1_addr = AW'(rs1); id_rs2_addr = AW'(rs2);
    id_rs1_used = u1; id_rs2_used = u2;
  endtask

  // inputs are set at the falling edge; outputs sampled 1 time unit before the rising edge
  task automatic dcyc(input string tag, input logic [6:0] exp);
    #4;
    check_out(tag, obs, exp);
    @(negedge clk);
  endtask

  task automatic model_eval(output logic [6:0] e, output int nf, output bit nw, output int nwd);
    bit lu;
    e = '0; nf = m_flush_left; nw = m_waiting; nwd = m_waited;
    lu = ex_en && ex_is_load && !ex_gpr_we_ && (ex_dst_addr != 0) && id_en &&
         ((id_rs1_used && id_rs1_addr == ex_dst_addr) || (id_rs2_used && id_rs2_addr == ex_dst_addr));
    if (m_flush_left > 0) begin
      e = 7'b0001100; nf = m_flush_left - 1;
    end else if (m_waiting) begin
      if (mem_ack) begin
        e = 7'b1110000; nw = 0;
      end else if (m_waited == MT - 1) begin
        e = 7'b0001101; nw = 0; nf = FC - 1;
      end else begin
        e = 7'b1110000; nwd = m_waited + 1;
      end
    end else if (trap_req) begin
      e = 7'b0001110; nf = FC - 1;
    end else if (ex_branch_taken) begin
      e = 7'b0001100; nf = FC - 1;
    end else if (mem_req && !mem_ack) begin
      e = 7'b1110000; nw = 1; nwd = 0;
    end else if (lu) begin
      e = 7'b1100100;
    end
  endtask

  initial begin
    logic [6:0] e;
    int nf, nwd;
    bit nw;

    clear_in();
    reset = 0;
    trap_req = 1; mem_req = 1;
    #4 check_out("reset_held", obs, 7'b0);
    @(negedge clk);
    clear_in();
    reset = 1;
    dcyc("idle", 7'b0);

    set_load(5, 1, 5, 1, 1);
    dcyc("lu_rs2", 7'b1100100);
    clear_in();
    dcyc("lu_after", 7'b0);
    set_load(0, 0, 0, 1, 1);
    dcyc("lu_x0", 7'b0);
    set_load(7, 7, 2, 0, 1);
    dcyc("lu_unused", 7'b0);
    clear_in();

    mem_req = 1;
    dcyc("mw_req", 7'b1110000);
    dcyc("mw_w0", 7'b1110000);
    dcyc("mw_w1", 7'b1110000);
    mem_ack = 1;
    dcyc("mw_ack", 7'b1110000);
    mem_req = 0; mem_ack = 0;
    dcyc("mw_done", 7'b0);

    mem_req = 1;
    dcyc("to_req", 7'b1110000);
    mem_req = 0;
    dcyc("to_w0", 7'b1110000);
    dcyc("to_w1", 7'b1110000);
    dcyc("to_w2", 7'b1110000);
    dcyc("to_pulse", 7'b0001101);
    dcyc("to_fl1", 7'b0001100);
    dcyc("to_fl2", 7'b0001100);
    dcyc("to_run", 7'b0);

    ex_branch_taken = 1;
    dcyc("br_c1", 7'b0001100);
    ex_branch_taken = 0; trap_req = 1;
    dcyc("br_c2", 7'b0001100);
    dcyc("br_c3", 7'b0001100);
    dcyc("trap_ack", 7'b0001110);
    trap_req = 0;
    dcyc("trap_fl1", 7'b0001100);
    dcyc("trap_fl2", 7'b0001100);
    dcyc("trap_run", 7'b0);

    trap_req = 1; ex_branch_taken = 1;
    dcyc("tb_both", 7'b0001110);
    trap_req = 0; ex_branch_taken = 0;
    dcyc("tb_fl1", 7'b0001100);
    dcyc("tb_fl2", 7'b0001100);

    mem_req = 1;
    dcyc("rst_req", 7'b1110000);
    dcyc("rst_w0", 7'b1110000);
    reset = 0;
    #1 check_out("rst_async", obs, 7'b0);
    @(negedge clk);
    reset = 1; mem_req = 0;
    dcyc("rst_run", 7'b0);
    mem_req = 1; mem_ack = 1;
    dcyc("single_cyc", 7'b0);
    clear_in();

    reset = 0;
    @(negedge clk);
    reset = 1;
    m_flush_left = 0; m_waiting = 0; m_waited = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!trap_req) trap_req = ($urandom_range(0, 11) == 0);
      ex_branch_taken = ($urandom_range(0, 7) == 0);
      mem_req = ($urandom_range(0, 3) == 0);
      mem_ack = ($urandom_range(0, 3) == 0);
      id_en = $urandom_range(0, 1); ex_en = $urandom_range(0, 1);
      ex_is_load = $urandom_range(0, 1); ex_gpr_we_ = $urandom_range(0, 1);
      id_rs1_used = $urandom_range(0, 1); id_rs2_used = $urandom_range(0, 1);
      id_rs1_addr = AW'($urandom_range(0, 3));
      id_rs2_addr = AW'($urandom_range(0, 3));
      ex_dst_addr = AW'($urandom_range(0, 3));
      #4;
      model_eval(e, nf, nw, nwd);
      check_out("rand", obs, e);
      @(negedge clk);
      m_flush_left = nf; m_waiting = nw; m_waited = nwd;
      if (e[1]) trap_req = 0;
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
